// File: rtl/mem_addr_trans_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_addr_trans_stage_pkg
// Brief   : Shared MMU types, access-type/size encodings and exception codes.
// Revision: 1.0 - initial release
// ============================================================================
package mem_addr_trans_stage_pkg;

    localparam logic [1:0] MMU_FETCH = 2'd0;
    localparam logic [1:0] MMU_LOAD  = 2'd1;
    localparam logic [1:0] MMU_STORE = 2'd2;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [5:0] ECODE_TLBR = 6'h3F;
    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_PIF  = 6'h03;
    localparam logic [5:0] ECODE_PME  = 6'h04;
    localparam logic [5:0] ECODE_PPI  = 6'h07;
    localparam logic [5:0] ECODE_ADE  = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;

    localparam logic [8:0] ESUBCODE_ADEF = 9'd0;
    localparam logic [8:0] ESUBCODE_NONE = 9'd0;

    typedef struct packed {
        logic        valid;
        logic [31:0] vaddr;
        logic [1:0]  mem_type;
        logic        cacop_direct;
    } MmuAddrTransReqSt;

    typedef struct packed {
        logic [31:0] paddr;
        logic        uncache;
        logic        tlbr;
        logic        pif;
        logic        pil;
        logic        pis;
        logic        ppi;
        logic        pme;
    } MmuAddrTransRspSt;

    typedef struct packed {
        logic [31:0] paddr;
        logic        uncache;
        logic        excp;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic [31:0] badv;
    } MemAddrTransRspSt;

endpackage
`default_nettype wire

// File: rtl/mem_excp_encoder.sv
`default_nettype none
// ============================================================================
// Module  : mem_excp_encoder
// Brief   : Fixed-priority exception encoder for a translated memory access.
// Revision: 1.0 - initial release
// ============================================================================
module mem_excp_encoder
    import mem_addr_trans_stage_pkg::*;
(
    input  logic [1:0] vaddr_lo_i,
    input  logic [1:0] mem_type_i,
    input  logic [1:0] size_i,
    input  logic       tlbr_i,
    input  logic       pif_i,
    input  logic       pil_i,
    input  logic       pis_i,
    input  logic       ppi_i,
    input  logic       pme_i,
    output logic       excp_o,
    output logic [5:0] ecode_o,
    output logic [8:0] esubcode_o
);

    logic w_adef;
    logic w_ale;
    logic w_data_access;

    assign w_data_access = (mem_type_i == MMU_LOAD) || (mem_type_i == MMU_STORE);
    assign w_adef        = (mem_type_i == MMU_FETCH) && (vaddr_lo_i != 2'b00);
    assign w_ale         = w_data_access &&
                           (((size_i == SIZE_HALF) && vaddr_lo_i[0]) ||
                            ((size_i == SIZE_WORD) && (vaddr_lo_i != 2'b00)));

    always_comb begin
        excp_o     = 1'b1;
        ecode_o    = 6'd0;
        esubcode_o = ESUBCODE_NONE;
        // Alignment faults are known before translation, so they beat any MMU fault.
        if (w_adef) begin
            ecode_o    = ECODE_ADE;
            esubcode_o = ESUBCODE_ADEF;
        end else if (w_ale) begin
            ecode_o = ECODE_ALE;
        end else if (tlbr_i) begin
            ecode_o = ECODE_TLBR;
        end else if (pif_i) begin
            ecode_o = ECODE_PIF;
        end else if (pil_i) begin
            ecode_o = ECODE_PIL;
        end else if (pis_i) begin
            ecode_o = ECODE_PIS;
        end else if (ppi_i) begin
            ecode_o = ECODE_PPI;
        end else if (pme_i) begin
            ecode_o = ECODE_PME;
        end else begin
            excp_o = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_addr_trans_stage.sv
`default_nettype none
// ============================================================================
// Module  : mem_addr_trans_stage
// Brief   : Two-stage address translation pipe: MMU request in S1, response reg in S2.
// Revision: 1.0 - initial release
// ============================================================================
module mem_addr_trans_stage
    import mem_addr_trans_stage_pkg::*;
#(
    parameter int TAG_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [31:0]       req_vaddr_i,
    input  logic [1:0]        req_mem_type_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_cacop_direct_i,
    input  logic [TAG_W-1:0]  req_tag_i,
    output MmuAddrTransReqSt  mmu_req_o,
    input  MmuAddrTransRspSt  mmu_rsp_i,
    input  logic              flush_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_paddr_o,
    output logic              rsp_uncache_o,
    output logic [TAG_W-1:0]  rsp_tag_o,
    output logic              rsp_excp_o,
    output logic [5:0]        rsp_ecode_o,
    output logic [8:0]        rsp_esubcode_o,
    output logic [31:0]       rsp_badv_o
);

    logic             s1_valid_q,    s1_valid_d;
    logic [31:0]      s1_vaddr_q,    s1_vaddr_d;
    logic [1:0]       s1_mem_type_q, s1_mem_type_d;
    logic [1:0]       s1_size_q,     s1_size_d;
    logic [TAG_W-1:0] s1_tag_q,      s1_tag_d;

    logic             s2_valid_q, s2_valid_d;
    MemAddrTransRspSt s2_rsp_q,   s2_rsp_d;
    logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;

    logic       w_s1_adv;
    logic       w_req_fire;
    logic       w_s1_excp;
    logic [5:0] w_s1_ecode;
    logic [8:0] w_s1_esubcode;

    // S1 may only take a new entry when its current one can move on; this keeps
    // the MMU's one-deep result buffer tied to whatever sits in S1.
    assign w_s1_adv    = !s2_valid_q || rsp_ready_i;
    assign req_ready_o = !rst && !flush_i && (!s1_valid_q || w_s1_adv);
    assign w_req_fire  = req_valid_i && req_ready_o;

    always_comb begin
        mmu_req_o              = '0;
        mmu_req_o.valid        = w_req_fire && !flush_i;
        mmu_req_o.vaddr        = req_vaddr_i;
        mmu_req_o.mem_type     = req_mem_type_i;
        mmu_req_o.cacop_direct = req_cacop_direct_i;
    end

    mem_excp_encoder u_excp_enc (
        .vaddr_lo_i (s1_vaddr_q[1:0]),
        .mem_type_i (s1_mem_type_q),
        .size_i     (s1_size_q),
        .tlbr_i     (mmu_rsp_i.tlbr),
        .pif_i      (mmu_rsp_i.pif),
        .pil_i      (mmu_rsp_i.pil),
        .pis_i      (mmu_rsp_i.pis),
        .ppi_i      (mmu_rsp_i.ppi),
        .pme_i      (mmu_rsp_i.pme),
        .excp_o     (w_s1_excp),
        .ecode_o    (w_s1_ecode),
        .esubcode_o (w_s1_esubcode)
    );

    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_vaddr_d    = s1_vaddr_q;
        s1_mem_type_d = s1_mem_type_q;
        s1_size_d     = s1_size_q;
        s1_tag_d      = s1_tag_q;
        s2_valid_d    = s2_valid_q;
        s2_rsp_d      = s2_rsp_q;
        s2_tag_d      = s2_tag_q;

        if (w_s1_adv) begin
            s2_valid_d = s1_valid_q;
            s1_valid_d = 1'b0;
            if (s1_valid_q) begin
                s2_rsp_d.paddr    = mmu_rsp_i.paddr;
                s2_rsp_d.uncache  = mmu_rsp_i.uncache && !w_s1_excp;
                s2_rsp_d.excp     = w_s1_excp;
                s2_rsp_d.ecode    = w_s1_ecode;
                s2_rsp_d.esubcode = w_s1_esubcode;
                s2_rsp_d.badv     = w_s1_excp ? s1_vaddr_q : 32'd0;
                s2_tag_d          = s1_tag_q;
            end
        end

        if (w_req_fire) begin
            s1_valid_d    = 1'b1;
            s1_vaddr_d    = req_vaddr_i;
            s1_mem_type_d = req_mem_type_i;
            s1_size_d     = req_size_i;
            s1_tag_d      = req_tag_i;
        end

        if (flush_i) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_vaddr_q    <= '0;
            s1_mem_type_q <= '0;
            s1_size_q     <= '0;
            s1_tag_q      <= '0;
            s2_valid_q    <= 1'b0;
            s2_rsp_q      <= '0;
            s2_tag_q      <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_vaddr_q    <= s1_vaddr_d;
            s1_mem_type_q <= s1_mem_type_d;
            s1_size_q     <= s1_size_d;
            s1_tag_q      <= s1_tag_d;
            s2_valid_q    <= s2_valid_d;
            s2_rsp_q      <= s2_rsp_d;
            s2_tag_q      <= s2_tag_d;
        end
    end

    assign rsp_valid_o    = s2_valid_q;
    assign rsp_paddr_o    = s2_rsp_q.paddr;
    assign rsp_uncache_o  = s2_rsp_q.uncache;
    assign rsp_tag_o      = s2_tag_q;
    assign rsp_excp_o     = s2_rsp_q.excp;
    assign rsp_ecode_o    = s2_rsp_q.ecode;
    assign rsp_esubcode_o = s2_rsp_q.esubcode;
    assign rsp_badv_o     = s2_rsp_q.badv;

endmodule
`default_nettype wire

// File: tb/tb_mem_addr_trans_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_addr_trans_stage
// Brief   : Directed + random bench with a queue-based pipeline reference model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_addr_trans_stage;
    import mem_addr_trans_stage_pkg::*;

    localparam int TW = 6;
    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] STORE = 2'd2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, req_valid, req_cacop, flush, rsp_ready;
    logic [31:0]      req_vaddr;
    logic [1:0]       req_mt, req_sz;
    logic [TW-1:0]    req_tag;
    MmuAddrTransReqSt mmu_req;
    MmuAddrTransRspSt mmu_rsp, plan_rsp;
    logic             req_ready, rsp_valid, rsp_uncache, rsp_excp;
    logic [31:0]      rsp_paddr, rsp_badv;
    logic [TW-1:0]    rsp_tag;
    logic [5:0]       rsp_ecode;
    logic [8:0]       rsp_esubcode;

    mem_addr_trans_stage #(.TAG_W(TW)) dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid_i        (req_valid),
        .req_ready_o        (req_ready),
        .req_vaddr_i        (req_vaddr),
        .req_mem_type_i     (req_mt),
        .req_size_i         (req_sz),
        .req_cacop_direct_i (req_cacop),
        .req_tag_i          (req_tag),
        .mmu_req_o          (mmu_req),
        .mmu_rsp_i          (mmu_rsp),
        .flush_i            (flush),
        .rsp_valid_o        (rsp_valid),
        .rsp_ready_i        (rsp_ready),
        .rsp_paddr_o        (rsp_paddr),
        .rsp_uncache_o      (rsp_uncache),
        .rsp_tag_o          (rsp_tag),
        .rsp_excp_o         (rsp_excp),
        .rsp_ecode_o        (rsp_ecode),
        .rsp_esubcode_o     (rsp_esubcode),
        .rsp_badv_o         (rsp_badv)
    );

    typedef struct {
        logic [31:0]   paddr;
        logic          unc;
        logic          excp;
        logic [5:0]    ecode;
        logic [31:0]   badv;
        logic [TW-1:0] tag;
        int            acc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0, bad = 0, cyc = 0, last_pop = -10, n_dlv = 0;
    logic acc_flag;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Expected response computed directly from the access rules.
    function automatic exp_t model(input logic [31:0] va, input logic [1:0] mt, input logic [1:0] sz,
                                   input logic [TW-1:0] tg, input MmuAddrTransRspSt r, input int c);
        exp_t e;
        logic misal;
        misal = (sz == 2'd1 && va[0]) || (sz == 2'd2 && va[1:0] != 2'b00);
        e.excp = 1'b1;
        e.ecode = 6'h00;
        if (mt == FETCH && va[1:0] != 2'b00)         e.ecode = 6'h08;
        else if ((mt == LOAD || mt == STORE) && misal) e.ecode = 6'h09;
        else if (r.tlbr)                              e.ecode = 6'h3F;
        else if (r.pif)                               e.ecode = 6'h03;
        else if (r.pil)                               e.ecode = 6'h01;
        else if (r.pis)                               e.ecode = 6'h02;
        else if (r.ppi)                               e.ecode = 6'h07;
        else if (r.pme)                               e.ecode = 6'h04;
        else                                          e.excp = 1'b0;
        e.paddr = r.paddr;
        e.unc   = e.excp ? 1'b0 : r.uncache;
        e.badv  = e.excp ? va : 32'd0;
        e.tag   = tg;
        e.acc   = c;
        return e;
    endfunction

    // flt = {tlbr, pif, pil, pis, ppi, pme}
    task automatic set_req(input logic v, input logic [31:0] va, input logic [1:0] mt, input logic [1:0] sz,
                           input logic [TW-1:0] tg, input logic [31:0] pa, input logic unc, input logic [5:0] flt);
        req_valid = v;  req_vaddr = va; req_mt = mt; req_sz = sz; req_tag = tg;
        req_cacop = 1'b0;
        plan_rsp.paddr = pa;      plan_rsp.uncache = unc;
        plan_rsp.tlbr  = flt[5];  plan_rsp.pif = flt[4]; plan_rsp.pil = flt[3];
        plan_rsp.pis   = flt[2];  plan_rsp.ppi = flt[1]; plan_rsp.pme = flt[0];
    endtask

    task automatic rand_req(input logic v);
        logic [31:0] va;
        logic [1:0]  mt;
        logic [5:0]  flt;
        va = $urandom;
        if ($urandom_range(0, 1) == 0) va[1:0] = 2'b00;
        mt = 2'($urandom_range(0, 2));
        flt = 6'd0;
        flt[5] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 5) == 0) flt[4 - mt] = 1'b1;
        flt[1] = ($urandom_range(0, 5) == 0);
        flt[0] = ($urandom_range(0, 5) == 0);
        set_req(v, va, mt, 2'($urandom_range(0, 2)), TW'($urandom), $urandom, 1'($urandom), flt);
        req_cacop = 1'($urandom);
    endtask

    // One clock: check at the negedge, advance the model after the posedge.
    task automatic tick(output logic acc);
        logic exp_rdy, exp_vld, dlv;
        int   vis;
        exp_t e, en;
        @(negedge clk);
        exp_rdy = !rst && !flush && (exp_q.size() < 2 || rsp_ready);
        chk("req_ready", req_ready, exp_rdy);
        chk("mmu_valid", mmu_req.valid, req_valid && exp_rdy);
        chk("mmu_vaddr", mmu_req.vaddr, req_vaddr);
        chk("mmu_type", mmu_req.mem_type, req_mt);
        chk("mmu_cacop", mmu_req.cacop_direct, req_cacop);
        exp_vld = 1'b0;
        if (exp_q.size() > 0) begin
            vis = exp_q[0].acc + 2;
            if (last_pop + 1 > vis) vis = last_pop + 1;
            exp_vld = (cyc >= vis);
        end
        chk("rsp_valid", rsp_valid, exp_vld);
        if (exp_vld) begin
            e = exp_q[0];
            chk("rsp_paddr", rsp_paddr, e.paddr);
            chk("rsp_uncache", rsp_uncache, e.unc);
            chk("rsp_excp", rsp_excp, e.excp);
            chk("rsp_ecode", rsp_ecode, e.ecode);
            chk("rsp_esubcode", rsp_esubcode, 0);
            chk("rsp_badv", rsp_badv, e.badv);
            chk("rsp_tag", rsp_tag, e.tag);
        end
        acc = req_valid && exp_rdy;
        dlv = exp_vld && rsp_ready;
        en  = model(req_vaddr, req_mt, req_sz, req_tag, plan_rsp, cyc);
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            acc = 1'b0;
        end else begin
            if (dlv) begin
                void'(exp_q.pop_front());
                last_pop = cyc;
                n_dlv++;
            end
            if (flush) exp_q.delete();
            else if (acc) begin
                exp_q.push_back(en);
                mmu_rsp = plan_rsp;
            end
        end
        cyc++;
    endtask

    task automatic chk_zero_outputs(input string pfx);
        chk({pfx, "_rsp_valid"}, rsp_valid, 0);
        chk({pfx, "_paddr"}, rsp_paddr, 0);
        chk({pfx, "_uncache"}, rsp_uncache, 0);
        chk({pfx, "_tag"}, rsp_tag, 0);
        chk({pfx, "_excp"}, rsp_excp, 0);
        chk({pfx, "_ecode"}, rsp_ecode, 0);
        chk({pfx, "_badv"}, rsp_badv, 0);
        chk({pfx, "_req_ready"}, req_ready, 0);
        chk({pfx, "_mmu_valid"}, mmu_req.valid, 0);
    endtask

    initial begin
        int idx, d0;
        rst = 1'b1; flush = 1'b0; rsp_ready = 1'b1; mmu_rsp = '0; plan_rsp = '0;
        set_req(1'b1, 32'h0, FETCH, 2'd2, '0, 32'h0, 1'b0, 6'd0);
        @(posedge clk);
        #1;
        tick(acc_flag);
        tick(acc_flag);
        chk_zero_outputs("reset");
        rst = 1'b0;

        // Aligned word load, clean translation
        set_req(1'b1, 32'h1C00_0100, LOAD, 2'd2, 6'h15, 32'h0000_0100, 1'b1, 6'd0);
        tick(acc_flag);
        chk("load_accept", acc_flag, 1);
        req_valid = 1'b0;
        tick(acc_flag);
        chk("load_t2_valid", rsp_valid, 1);
        chk("load_t2_paddr", rsp_paddr, 32'h0000_0100);
        chk("load_t2_excp", rsp_excp, 0);
        chk("load_t2_tag", rsp_tag, 6'h15);
        tick(acc_flag);

        // Misaligned half store: ALE must beat PME
        set_req(1'b1, 32'h1000_0003, STORE, 2'd1, 6'h02, 32'h8000_0003, 1'b1, 6'b000001);
        tick(acc_flag);
        req_valid = 1'b0;
        tick(acc_flag);
        chk("ale_ecode", rsp_ecode, 6'h09);
        chk("ale_badv", rsp_badv, 32'h1000_0003);
        chk("ale_uncache", rsp_uncache, 0);
        tick(acc_flag);

        // Fetch with TLB refill and fetch-invalid: TLBR wins
        set_req(1'b1, 32'h1C00_0000, FETCH, 2'd2, 6'h33, 32'h0, 1'b0, 6'b110000);
        tick(acc_flag);
        req_valid = 1'b0;
        tick(acc_flag);
        chk("tlbr_ecode", rsp_ecode, 6'h3F);
        chk("tlbr_esub", rsp_esubcode, 0);
        tick(acc_flag);

        // Four back-to-back requests, consumer stalled for three cycles
        idx = 0;
        d0  = n_dlv;
        for (int c = 0; c < 12; c++) begin
            rsp_ready = (c >= 3);
            if (idx < 4) set_req(1'b1, 32'h2000_0000 + 32'(idx * 4), LOAD, 2'd2, TW'(8 + idx),
                                 32'h0040_0000 + 32'(idx * 4), 1'b0, 6'd0);
            else req_valid = 1'b0;
            if (c == 2) begin
                chk("b2b_ready_drop", req_ready, 0);
                chk("b2b_mmu_quiet", mmu_req.valid, 0);
            end
            tick(acc_flag);
            if (acc_flag) idx++;
        end
        chk("b2b_accepts", idx, 4);
        chk("b2b_responses", n_dlv - d0, 4);

        // Flush with both stages full and consumer stalled
        rsp_ready = 1'b0;
        rand_req(1'b1); tick(acc_flag);
        rand_req(1'b1); tick(acc_flag);
        d0 = n_dlv;
        flush = 1'b1;
        rand_req(1'b1);
        chk("flush_no_ready", req_ready, 0);
        tick(acc_flag);
        flush = 1'b0;
        req_valid = 1'b0;
        chk("flush_rsp_gone", rsp_valid, 0);
        rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick(acc_flag);
        chk("flush_no_rsp", n_dlv - d0, 0);

        // Flush coinciding with a completed handshake
        rsp_ready = 1'b0;
        rand_req(1'b1); tick(acc_flag);
        rand_req(1'b1); tick(acc_flag);
        d0 = n_dlv;
        rsp_ready = 1'b1;
        flush = 1'b1;
        req_valid = 1'b0;
        tick(acc_flag);
        flush = 1'b0;
        for (int c = 0; c < 4; c++) tick(acc_flag);
        chk("flush_hs_one_rsp", n_dlv - d0, 1);

        // Reset in the middle of a stall, then a fresh request
        rsp_ready = 1'b0;
        rand_req(1'b1); tick(acc_flag);
        rand_req(1'b1); tick(acc_flag);
        rand_req(1'b1); tick(acc_flag);
        rst = 1'b1;
        tick(acc_flag);
        chk_zero_outputs("midrst");
        rst = 1'b0;
        rsp_ready = 1'b1;
        d0 = n_dlv;
        set_req(1'b1, 32'h0000_2004, LOAD, 2'd2, 6'h2A, 32'h0001_2004, 1'b1, 6'd0);
        tick(acc_flag);
        req_valid = 1'b0;
        tick(acc_flag);
        chk("post_rst_valid", rsp_valid, 1);
        chk("post_rst_tag", rsp_tag, 6'h2A);
        tick(acc_flag);
        chk("post_rst_rsp", n_dlv - d0, 1);

        // Random traffic against the queue model
        for (int c = 0; c < 400; c++) begin
            rand_req($urandom_range(0, 9) < 7);
            rsp_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 24) == 0);
            tick(acc_flag);
        end
        flush = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick(acc_flag);
        chk("drain_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_addr_trans_stage.md
MEM_ADDR_TRANS_STAGE -- requirements
Module: mem_addr_trans_stage

Interface
REQ-001 SHALL have parameter TAG_W, default 6, giving the width of the opaque request tag (ROB/LSU id).
REQ-002 SHALL have port clk, input, 1: the single clock.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port req_valid_i / req_ready_o, in/out, 1/1: upstream handshake.
REQ-005 SHALL have port req_vaddr_i, in, 32: virtual address.
REQ-006 SHALL have port req_mem_type_i, in, 2: MMU_FETCH / MMU_LOAD / MMU_STORE.
REQ-007 SHALL have port req_size_i, in, 2: access size; 0 = byte, 1 = half, 2 = word.
REQ-008 SHALL have port req_cacop_direct_i, in, 1: bypass translation.
REQ-009 SHALL have port req_tag_i, in, TAG_W: tag carried through to the response.
REQ-010 SHALL have port mmu_req_o, out, MmuAddrTransReqSt: translation request to the MMU.
REQ-011 SHALL have port mmu_rsp_i, in, MmuAddrTransRspSt: MMU result, valid the cycle after a request.
REQ-012 SHALL have port flush_i, in, 1: pipeline flush.
REQ-013 SHALL have port rsp_valid_o / rsp_ready_i, out/in, 1/1: downstream handshake.
REQ-014 SHALL have ports rsp_paddr_o, out, 32; rsp_uncache_o, out, 1; rsp_tag_o, out, TAG_W.
REQ-015 SHALL have ports rsp_excp_o, out, 1; rsp_ecode_o, out, 6; rsp_esubcode_o, out, 9; rsp_badv_o, out, 32.

Function
REQ-016 SHALL form two stages: S1 (request issued, MMU result pending) and S2 (output register); each stage holds one entry with a valid bit.
REQ-017 SHALL drive mmu_req_o.valid = req_valid_i && req_ready_o && !flush_i, with vaddr, mem_type and cacop_direct passed through combinationally.
REQ-018 SHALL define s1_adv = !s2_valid || rsp_ready_i, and req_ready_o = !flush_i && (!s1_valid || s1_adv).
REQ-019 SHALL, on accept, register vaddr, mem_type, size and tag into S1 and set s1_valid.
REQ-020 SHALL, when s1_valid && s1_adv, register the S1 result into S2; latency is accept at cycle T, rsp_valid_o at T+2; back-to-back accepts SHALL give one response per cycle.
REQ-021 SHALL never issue a new MMU request while S1 is stalled, so the MMU's internal request buffer, and hence mmu_rsp_i, stays bound to the S1 entry.
REQ-022 SHALL detect address errors in S1: FETCH with vaddr[1:0]!=0 gives ADEF (ecode 0x08, esubcode 0); LOAD/STORE with (size 1 && vaddr[0]) or (size 2 && vaddr[1:0]!=0) gives ALE (ecode 0x09).
REQ-023 SHALL encode exceptions with fixed priority ADEF/ALE > TLBR (0x3F) > PIF (0x03) / PIL (0x01) / PIS (0x02) > PPI (0x07) > PME (0x04); esubcode is 0 except as given in REQ-022.
REQ-024 SHALL set rsp_excp_o when any exception is encoded; rsp_badv_o = S1 vaddr whenever excp, else 0.
REQ-025 SHALL pass rsp_paddr_o and rsp_uncache_o from mmu_rsp_i unchanged, and force rsp_uncache_o = 0 when excp.
REQ-026 SHALL hold all S2 outputs stable while rsp_valid_o && !rsp_ready_i.
REQ-027 SHALL, on flush_i, clear s1_valid and s2_valid at that edge, accept no request in that cycle, and drop any in-flight MMU result.
REQ-028 SHALL, when a flush coincides with rsp_ready_i, complete the downstream handshake in that cycle and emit no further response.

Reset
REQ-029 SHALL, while rst is high at a clock edge, clear s1_valid and s2_valid, zero all S2 payload registers, and hold req_ready_o and mmu_req_o.valid at 0.
REQ-030 SHALL make rst override flush_i and handshakes, and drop any operation in flight.

Structure
REQ-031 SHALL place the ecode/esubcode constants (TLBR, PIL, PIS, PIF, PME, PPI, ADE, ALE) and the response struct in the shared MMU header, alongside MmuAddrTransReqSt/RspSt.
REQ-032 SHALL implement the priority encoding as a combinational sub-module mem_excp_encoder.

Verification
REQ-033 SHALL cover: aligned word LOAD 0x1C00_0100, MMU paddr 0x0000_0100, no fault -> rsp_valid_o at T+2, excp=0, tag echoed.
REQ-034 SHALL cover: half STORE at 0x1000_0003 with MMU pme=1 -> ecode 0x09, badv 0x1000_0003 (ALE wins over PME).
REQ-035 SHALL cover: FETCH with MMU tlbr=1 and pif=1 -> ecode 0x3F, esubcode 0.
REQ-036 SHALL cover: 4 back-to-back requests with rsp_ready_i low for 3 cycles -> req_ready_o drops after 2 accepts, mmu_req_o.valid stays low while stalled, and 4 in-order responses follow with no loss or duplication.
REQ-037 SHALL cover: flush_i with both stages full -> rsp_valid_o=0 next cycle and no response for either entry.
REQ-038 SHALL cover: rst asserted mid-stall -> all outputs zero the next cycle, and a fresh request then completes normally.
